// File: rtl/jt51_wrq_pkg.sv
// Shared types for the jt51 CPU write queue: FSM state encodings and FIFO entry layout.
package jt51_wrq_pkg;

  localparam int unsigned ENTRY_W = 16;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_GAP1  = 3'd2,
    S_DATA  = 3'd3,
    S_HOLD  = 3'd4,
    S_WAITB = 3'd5
  } state_t;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } wrq_entry_t;

endpackage

// File: rtl/jt51_wrq_fifo.sv
// Generic synchronous FIFO; push while full is accepted only alongside a pop, read data registered on pop.
module jt51_wrq_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [15:0]   wdata,
  output logic [15:0]   rdata,
  output logic [AW:0]   level,
  output logic          full
);

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          acc;
  logic [AW:0]   level_d;

  assign acc = push & (~full | pop);

  // Next occupancy: simultaneous accepted push and pop leaves it unchanged.
  always_comb begin
    level_d = level;
    if (acc && !pop)      level_d = level + (AW+1)'(1);
    else if (pop && !acc) level_d = level - (AW+1)'(1);
  end

  // Pointers, occupancy, full flag and registered head read.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      rdata  <= '0;
    end else begin
      if (acc) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        rdata  <= mem[rd_ptr];
      end
      level <= level_d;
      full  <= (level_d == (AW+1)'(DEPTH));
    end
  end

  // Storage array, no reset needed.
  always_ff @(posedge clk) begin
    if (acc) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/jt51_wrq.sv
// CPU register write queue: buffers {address, data} pairs and replays them to the MMR stage paced by busy.
module jt51_wrq
  import jt51_wrq_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_wr,
  input  logic          cpu_a0,
  input  logic [7:0]    cpu_din,
  input  logic          mmr_busy,
  output logic          write,
  output logic          a0,
  output logic [7:0]    dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level,
  output logic          ovf,
  input  logic          clr_ovf
);

  state_t      state;
  state_t      state_d;
  logic [7:0]  shadow;
  logic        push;
  logic        pop;
  logic        acc;
  logic [15:0] rdata;
  wrq_entry_t  head;
  wrq_entry_t  wentry;
  logic [AW:0] level_d;
  logic        write_d;
  logic        a0_d;
  logic [7:0]  dout_d;

  assign push        = cpu_wr & cpu_a0;
  assign acc         = push & (~full | pop);
  assign wentry.addr = shadow;
  assign wentry.data = cpu_din;
  assign head        = wrq_entry_t'(rdata);

  jt51_wrq_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (16'(wentry)),
    .rdata (rdata),
    .level (level),
    .full  (full)
  );

  // Occupancy after this clk, used to register the empty flag.
  always_comb begin
    level_d = level;
    if (acc && !pop)      level_d = level + (AW+1)'(1);
    else if (pop && !acc) level_d = level - (AW+1)'(1);
  end

  // Replay sequencer: pop, address write, gap, data write, hold, wait for busy to clear.
  always_comb begin
    state_d = state;
    pop     = 1'b0;
    write_d = 1'b0;
    a0_d    = a0;
    dout_d  = dout;
    case (state)
      S_IDLE: begin
        if ((level != '0) && !mmr_busy) begin
          pop     = 1'b1;
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        write_d = 1'b1;
        a0_d    = 1'b0;
        dout_d  = head.addr;
        state_d = S_GAP1;
      end
      S_GAP1:  state_d = S_DATA;
      S_DATA: begin
        write_d = 1'b1;
        a0_d    = 1'b1;
        dout_d  = head.data;
        state_d = S_HOLD;
      end
      S_HOLD:  state_d = S_WAITB;
      S_WAITB: if (!mmr_busy) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, registered MMR outputs, shadow address, sticky overflow and empty flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      write  <= 1'b0;
      a0     <= 1'b0;
      dout   <= 8'h00;
      shadow <= 8'h00;
      ovf    <= 1'b0;
      empty  <= 1'b1;
    end else begin
      state <= state_d;
      write <= write_d;
      a0    <= a0_d;
      dout  <= dout_d;
      if (cpu_wr && !cpu_a0) shadow <= cpu_din;
      if (push && !acc)      ovf <= 1'b1;
      else if (clr_ovf)      ovf <= 1'b0;
      empty <= (level_d == '0) && (state_d == S_IDLE);
    end
  end

endmodule
